// File: rtl/sram_ctrl_if.sv
// Signal bundle between bus-side logic, sram_ctrl and the asynchronous SRAM macro.
// The slave modport is the controller view; master is the surrounding environment.
interface sram_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          sram_cs;
  logic          sram_rd;
  logic          sram_wr;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sram_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           sram_cs, sram_rd, sram_wr, sram_addr, sram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, sram_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           sram_cs, sram_rd, sram_wr, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_ctrl.sv
// Sequences cs/rd/wr strobes for the asynchronous 8-bit SRAM macro from a valid/ready stream.
// Optional write read-back check is compiled in with `define SRAM_CTRL_VERIFY_EN.
module sram_ctrl #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int WR_PULSE = 1,
  parameter int RD_WAIT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  sram_ctrl_if.slave bus
);

  localparam int CNT_MAX = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_WAIT
`ifdef SRAM_CTRL_VERIFY_EN
    , S_VRFY
`endif
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic          r_cs, w_cs_nxt;
  logic          r_rd, w_rd_nxt;
  logic          r_wr, w_wr_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [DW-1:0] r_din, w_din_nxt;
  logic          w_accept;
`ifdef SRAM_CTRL_VERIFY_EN
  logic          r_err, w_err_nxt;
`endif

  assign w_accept = bus.req_valid && r_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_ready_nxt     = r_ready;
    w_rsp_valid_nxt = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_cs_nxt        = r_cs;
    w_rd_nxt        = r_rd;
    w_wr_nxt        = r_wr;
    w_addr_nxt      = r_addr;
    w_din_nxt       = r_din;
`ifdef SRAM_CTRL_VERIFY_EN
    w_err_nxt       = 1'b0;
`endif

    unique case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        if (w_accept) begin
          w_ready_nxt = 1'b0;
          w_cs_nxt    = 1'b1;
          w_addr_nxt  = bus.req_addr;
          if (bus.req_we) begin
            w_din_nxt   = bus.req_wdata;
            w_state_nxt = S_WR_SETUP;
          end else begin
            w_rd_nxt    = 1'b0;
            w_cnt_nxt   = RD_LOAD;
            w_state_nxt = S_RD_WAIT;
          end
        end
      end

      S_WR_SETUP: begin
        w_wr_nxt    = 1'b1;
        w_cnt_nxt   = WR_LOAD;
        w_state_nxt = S_WR_PULSE;
      end

      S_WR_PULSE: begin
        if (r_cnt == '0) begin
          w_wr_nxt    = 1'b0;
          w_state_nxt = S_WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      S_WR_HOLD: begin
`ifdef SRAM_CTRL_VERIFY_EN
        // Read back the just-written location before reporting completion.
        w_rd_nxt    = 1'b0;
        w_cnt_nxt   = RD_LOAD;
        w_state_nxt = S_VRFY;
`else
        w_cs_nxt        = 1'b0;
        w_rsp_valid_nxt = 1'b1;
        w_ready_nxt     = 1'b1;
        w_state_nxt     = S_IDLE;
`endif
      end

      S_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_rdata_nxt     = bus.sram_dout;
          w_cs_nxt        = 1'b0;
          w_rd_nxt        = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_ready_nxt     = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

`ifdef SRAM_CTRL_VERIFY_EN
      S_VRFY: begin
        if (r_cnt == '0) begin
          w_err_nxt       = (bus.sram_dout != r_din);
          w_cs_nxt        = 1'b0;
          w_rd_nxt        = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_ready_nxt     = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
`endif

      default: begin
        w_cs_nxt    = 1'b0;
        w_rd_nxt    = 1'b1;
        w_wr_nxt    = 1'b0;
        w_ready_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_cs        <= 1'b0;
      r_rd        <= 1'b1;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
`ifdef SRAM_CTRL_VERIFY_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ready     <= w_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rdata     <= w_rdata_nxt;
      r_cs        <= w_cs_nxt;
      r_rd        <= w_rd_nxt;
      r_wr        <= w_wr_nxt;
      r_addr      <= w_addr_nxt;
      r_din       <= w_din_nxt;
`ifdef SRAM_CTRL_VERIFY_EN
      r_err       <= w_err_nxt;
`endif
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.sram_cs   = r_cs;
  assign bus.sram_rd   = r_rd;
  assign bus.sram_wr   = r_wr;
  assign bus.sram_addr = r_addr;
  assign bus.sram_din  = r_din;
`ifdef SRAM_CTRL_VERIFY_EN
  assign bus.rsp_err   = r_err;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: random and directed requests against a behavioural SRAM model,
// plus a second instance with WR_PULSE=2, RD_WAIT=3 for strobe-length checks.
`timescale 1ns/1ps
module tb_sram_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef SRAM_CTRL_VERIFY_EN
  localparam bit            VERIFY     = 1'b1;
  localparam logic [DW-1:0] STUCK_MASK = 8'hFE;
`else
  localparam bit            VERIFY     = 1'b0;
  localparam logic [DW-1:0] STUCK_MASK = 8'hFF;
`endif
  // Response edge relative to the accept edge, for WR_PULSE=1, RD_WAIT=1.
  localparam int WR_LAT = 2 + 1 + (VERIFY ? 1 : 0);
  localparam int RD_LAT = 1;
  // Second instance: WR_PULSE=2, RD_WAIT=3.
  localparam int P_WP = 2;
  localparam int P_RW = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  sram_ctrl_if #(.AW(AW), .DW(DW)) bus3 ();

  sram_ctrl #(.AW(AW), .DW(DW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  sram_ctrl #(.AW(AW), .DW(DW), .WR_PULSE(P_WP), .RD_WAIT(P_RW)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Asynchronous SRAM macros: write on rising sram_wr, dout driven only while reading.
  logic [DW-1:0] sram_mem  [256];
  logic [DW-1:0] sram_mem3 [256];
  int wr_edges = 0;

  always @(posedge bus.sram_wr) if (bus.sram_cs) begin
    sram_mem[bus.sram_addr] = bus.sram_din;
    wr_edges++;
  end
  always @(posedge bus3.sram_wr) if (bus3.sram_cs) sram_mem3[bus3.sram_addr] = bus3.sram_din;

  assign bus.sram_dout  = (bus.sram_cs && !bus.sram_rd) ? (sram_mem[bus.sram_addr] & STUCK_MASK) : 'z;
  assign bus3.sram_dout = (bus3.sram_cs && !bus3.sram_rd) ? sram_mem3[bus3.sram_addr] : 'z;

  // Reference model and scoreboard.
  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            edge_no;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] model_last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: protocol rules every cycle, responses popped from the scoreboard.
  logic          prev_cs = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_din;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.sram_wr || !bus.sram_rd) begin
        check("rd_wr_exclusive", {31'b0, bus.sram_wr && !bus.sram_rd}, 32'd0);
        check("strobe_needs_cs", {31'b0, bus.sram_cs}, 32'd1);
      end
      if (bus.sram_cs && prev_cs) begin
        check("addr_stable", {24'b0, bus.sram_addr}, {24'b0, prev_addr});
        check("din_stable", {24'b0, bus.sram_din}, {24'b0, prev_din});
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with no operation outstanding (cycle %0d)", cyc);
        end else begin
          check("rsp_edge", cyc, exp_q[0].edge_no);
          check("rsp_rdata", {24'b0, bus.rsp_rdata}, {24'b0, exp_q[0].rdata});
          check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp_q[0].err});
          void'(exp_q.pop_front());
        end
      end
      prev_cs   <= bus.sram_cs;
      prev_addr <= bus.sram_addr;
      prev_din  <= bus.sram_din;
    end else begin
      prev_cs <= 1'b0;
    end
  end

  // Issue one request starting at a negedge; returns the accept edge number.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input bit noise, output int acc);
    int guard = 0;
    logic [DW-1:0] rd;
    acc = -1;
    while (bus.req_ready !== 1'b1) begin
      if (guard > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_timeout: req_ready=0 for %0d cycles, expected 1", guard);
        return;
      end
      if (noise) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
      end else begin
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
      end
      @(negedge clk);
      guard++;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    acc = cyc + 1;
    if (we) begin
      model_mem[addr] = wdata;
      exp_q.push_back('{rdata: model_last_rd, err: VERIFY && ((wdata & STUCK_MASK) != wdata),
                        edge_no: acc + WR_LAT});
    end else begin
      rd = model_mem[addr] & STUCK_MASK;
      model_last_rd = rd;
      exp_q.push_back('{rdata: rd, err: 1'b0, edge_no: acc + RD_LAT});
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard = 0;
    bus.req_valid = 1'b0;
    while (exp_q.size() != 0) begin
      if (guard > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
        exp_q.delete();
        return;
      end
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
  endtask

  // Strobe lengths on the second instance, sampled at each rising edge.
  int wr3_high = 0;
  int rd3_low  = 0;
  always @(posedge clk) begin
    if (bus3.sram_wr === 1'b1) wr3_high <= wr3_high + 1;
    if (bus3.sram_rd === 1'b0) rd3_low  <= rd3_low + 1;
  end

  task automatic issue3(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int lat, input int wr_cycles, input int rd_cycles,
                        input logic [DW-1:0] exp_rdata, input string tag);
    int guard = 0;
    int a0, w0, r0;
    while (bus3.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus3.req_valid = 1'b1;
    bus3.req_we    = we;
    bus3.req_addr  = addr;
    bus3.req_wdata = wdata;
    a0 = cyc + 1;
    w0 = wr3_high;
    r0 = rd3_low;
    @(negedge clk);
    bus3.req_valid = 1'b0;
    guard = 0;
    while (bus3.rsp_valid !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_rsp_edge"}, cyc, a0 + lat);
    check({tag, "_wr_cycles"}, wr3_high - w0, wr_cycles);
    check({tag, "_rd_cycles"}, rd3_low - r0, rd_cycles);
    check({tag, "_rdata"}, {24'b0, bus3.rsp_rdata}, {24'b0, exp_rdata});
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1, a2, a3, a4, acc, we0;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i]  = DW'($urandom);
      model_mem[i] = sram_mem[i];
      sram_mem3[i] = '0;
    end
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus3.req_valid = 1'b0;
    bus3.req_we    = 1'b0;
    bus3.req_addr  = '0;
    bus3.req_wdata = '0;

    // Reset state and release.
    repeat (3) @(negedge clk);
    check("rst_cs", {31'b0, bus.sram_cs}, 32'd0);
    check("rst_rd", {31'b0, bus.sram_rd}, 32'd1);
    check("rst_wr", {31'b0, bus.sram_wr}, 32'd0);
    check("rst_addr", {24'b0, bus.sram_addr}, 32'd0);
    check("rst_din", {24'b0, bus.sram_din}, 32'd0);
    check("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rdata", {24'b0, bus.rsp_rdata}, 32'd0);
    check("rst_err", {31'b0, bus.rsp_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_first_edge", {31'b0, bus.req_ready}, 32'd1);
    check("idle_cs", {31'b0, bus.sram_cs}, 32'd0);
    check("idle_rd", {31'b0, bus.sram_rd}, 32'd1);

    // Directed write then read-back.
    we0 = wr_edges;
    issue(1'b1, 8'h3C, 8'hA5, 1'b0, acc);
    wait_idle();
    check("single_write_edge", wr_edges - we0, 32'd1);
    issue(1'b0, 8'h3C, 8'h00, 1'b0, acc);
    wait_idle();

    // Back-to-back with req_valid held high.
    issue(1'b1, 8'h00, 8'h11, 1'b0, a1);
    issue(1'b1, 8'hFF, 8'h22, 1'b0, a2);
    issue(1'b0, 8'hFF, 8'h00, 1'b0, a3);
    issue(1'b0, 8'h00, 8'h00, 1'b0, a4);
    wait_idle();
    check("b2b_gap_wr_wr", a2 - a1, WR_LAT + 1);
    check("b2b_gap_wr_rd", a3 - a2, WR_LAT + 1);
    check("b2b_gap_rd_rd", a4 - a3, RD_LAT + 1);

    // Reset during WR_SETUP aborts the write.
    we0 = wr_edges;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'h10;
    bus.req_wdata = 8'h77;
    @(negedge clk);
    check("abort_in_setup_cs", {31'b0, bus.sram_cs}, 32'd1);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_cs", {31'b0, bus.sram_cs}, 32'd0);
    check("abort_wr", {31'b0, bus.sram_wr}, 32'd0);
    check("abort_rd", {31'b0, bus.sram_rd}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_back", {31'b0, bus.req_ready}, 32'd1);
    check("abort_no_wr_edge", wr_edges - we0, 32'd0);
    model_last_rd = '0;
    issue(1'b0, 8'h10, 8'h00, 1'b0, acc);
    wait_idle();

    // Verify-path values (response error flagged only with the read-back feature and a stuck bit).
    issue(1'b1, 8'h20, 8'h05, 1'b0, acc);
    issue(1'b1, 8'h20, 8'h04, 1'b0, acc);
    wait_idle();

    // Randomized traffic with garbage on the bus while busy and random idle gaps.
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        bus.req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(1'($urandom_range(0, 1)), ra, DW'($urandom), 1'($urandom_range(0, 1)), acc);
    end
    wait_idle();

    // Longer strobes on the second instance.
    issue3(1'b1, 8'h3C, 8'h5A, 2 + P_WP + (VERIFY ? P_RW : 0), P_WP, VERIFY ? P_RW : 0, 8'h00, "p_write");
    issue3(1'b0, 8'h3C, 8'h00, P_RW, 0, P_RW, 8'h5A, "p_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Synchronous initiator for the team's asynchronous 8-bit SRAM macro port: cs (active-high), rd (active-low read enable), wr (write on rising edge), separate din/dout buses, tri-stated dout.
- Converts a single-clock valid/ready request stream into correctly sequenced SRAM strobes and returns read data as a one-cycle response pulse.
- Sits between bus-side logic and the SRAM macro; one outstanding operation at a time.

Parameters:
- AW, 8, address width; must match the SRAM address port.
- DW, 8, data width; must match the SRAM data ports.
- WR_PULSE, 1, number of cycles sram_wr is held high (min 1).
- RD_WAIT, 1, cycles sram_rd is held low before read data is sampled (min 1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller idle; a request is accepted when req_valid && req_ready at a clock edge.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  AW  request address.
- req_wdata  input  DW  write data.
- rsp_valid  output  1  one-cycle completion pulse for reads and writes; no backpressure.
- rsp_rdata  output  DW  read data; valid while rsp_valid is high after a read.
- rsp_err  output  1  verify mismatch; see Optional Feature.
- sram_cs  output  1  SRAM chip select.
- sram_rd  output  1  SRAM read enable, active-low.
- sram_wr  output  1  SRAM write strobe; memory is written on its rising edge.
- sram_addr  output  AW  SRAM address.
- sram_din  output  DW  SRAM write data.
- sram_dout  input  DW  SRAM read data; may be Z outside reads.

Behaviour:
- Reset is asynchronous: while rst_n is low, all outputs are registered to idle values.
  - sram_cs=0, sram_rd=1, sram_wr=0, sram_addr=0, sram_din=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - State is IDLE.
  - req_ready rises at the first clock edge after rst_n deasserts.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT (plus VRFY when the optional feature is compiled in).
- req_ready is a registered output; it is 1 only in IDLE and drops at the accepting edge.
- The accept edge is edge 0. On accept, sram_addr and sram_din (for writes) are latched and held constant until the operation returns to IDLE.
- Write sequence:
  - Edge 0: enter WR_SETUP; sram_cs=1, sram_wr=0.
  - Edge 1: enter WR_PULSE; sram_wr=1 for WR_PULSE cycles.
  - Edge 1+WR_PULSE: enter WR_HOLD; sram_wr=0, sram_cs=1.
  - Edge 2+WR_PULSE: enter IDLE; sram_cs=0, rsp_valid=1 for one cycle, rsp_rdata unchanged.
  - Address and data are therefore stable at least one cycle before and one cycle after the sram_wr rising edge.
- Read sequence:
  - Edge 0: enter RD_WAIT; sram_cs=1, sram_rd=0, counter loaded.
  - Edge RD_WAIT: sram_dout is captured into rsp_rdata; enter IDLE with sram_cs=0, sram_rd=1, rsp_valid=1 for one cycle.
- sram_rd and sram_wr are never active in the same cycle. sram_dout is sampled only at the final RD_WAIT edge.
- rsp_rdata holds the last read value until the next read completes.
- Back-to-back operation: req_ready is 1 in the same cycle rsp_valid is high, so a new request can be accepted there.
  - Write cost is 3+WR_PULSE cycles per operation; read cost is 1+RD_WAIT cycles.
- req_valid while req_ready=0 is ignored; requests are not queued.
- Reset mid-operation:
  - Strobes return to idle immediately.
  - A reset during WR_SETUP produces no sram_wr rising edge, so no write occurs.
  - A reset during or after WR_PULSE leaves the write already committed.
  - No rsp_valid is generated for an aborted operation.

Optional Feature:
- Macro: SRAM_CTRL_VERIFY_EN.
- Defined:
  - After WR_HOLD, the FSM enters VRFY: sram_cs=1, sram_rd=0 for RD_WAIT cycles at the same address.
  - sram_dout is compared with the latched write data.
  - On return to IDLE, rsp_valid=1 and rsp_err=1 if they differ, else 0; rsp_err is valid only with rsp_valid.
  - Write latency grows by RD_WAIT cycles; rsp_rdata is not updated by the verify read.
- Undefined: there is no VRFY state, rsp_err is tied 0, and timing is as in Behaviour.

Test Plan:
- Reset release, req_valid=0: req_ready goes 1 one edge after release; sram_cs=0, sram_rd=1, sram_wr=0.
- Write addr 0x3C data 0xA5 (defaults): exactly one sram_wr rising edge; sram_addr=0x3C and sram_din=0xA5 stable one cycle before and after it; rsp_valid pulses 3 edges after accept.
- Read addr 0x3C after the write: sram_rd low for 1 cycle; rsp_rdata=0xA5 with rsp_valid at edge 1. With RD_WAIT=3: rd low for 3 cycles, response at edge 3.
- Back-to-back: write 0x00/0x11, write 0xFF/0x22, read 0xFF, read 0x00 with req_valid held high: no idle gaps beyond the stated costs; reads return 0x22 then 0x11; rd and wr never active together.
- rst_n pulsed low during WR_SETUP of write 0x10/0x77: no sram_wr edge; a later read of 0x10 returns the prior contents; no rsp_valid for the aborted write.
- With SRAM_CTRL_VERIFY_EN, SRAM model forcing bit 0 stuck-at-0, write 0x05 to 0x20: rsp_err=1 with rsp_valid. Writing 0x04 gives rsp_err=0.
